// File: rtl/fnn_pkg.sv
// ============================================================================
// fnn_pkg: shared types and defaults for the NN4 output/argmax path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fnn_pkg;

    localparam int CLASS_W          = 4;
    localparam int DEF_NN4          = 10;
    localparam int DEF_INDATA_WIDTH = 47;

    typedef enum logic [2:0] {
        SS_IDLE   = 3'd0,
        SS_FILL   = 3'd1,
        SS_CLEAR  = 3'd2,
        SS_STREAM = 3'd3,
        SS_WAIT   = 3'd4
    } ss_state_t;

endpackage

`default_nettype wire

// File: rtl/score_buffer.sv
// ============================================================================
// score_buffer: NN4-entry score register file with a per-entry valid mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_buffer
    import fnn_pkg::*;
#(
    parameter int NN4          = DEF_NN4,
    parameter int INDATA_WIDTH = DEF_INDATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [CLASS_W-1:0]      wr_idx,
    input  logic [INDATA_WIDTH-1:0] wr_data,
    input  logic [CLASS_W-1:0]      rd_idx,
    input  logic                    clear,
    output logic [INDATA_WIDTH-1:0] rd_data,
    output logic                    all_valid
);

    logic [INDATA_WIDTH-1:0] r_mem [NN4];
    logic [NN4-1:0]          r_mask;
    logic [NN4-1:0]          w_set;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < NN4; i++) begin
            if (wr_en && (wr_idx == CLASS_W'(i))) begin
                w_set[i] = 1'b1;
            end
        end
    end

    // Includes the write being accepted this cycle, so the caller can leave FILL on that same edge.
    assign all_valid = &(r_mask | w_set);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NN4; i++) begin
            if (w_set[i]) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NN4; i++) begin
            if (rd_idx == CLASS_W'(i)) begin
                rd_data = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (clear) begin
            r_mask <= '0;
        end else begin
            r_mask <= r_mask | w_set;
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_score_streamer.sv
// ============================================================================
// output_score_streamer: collects output scores, replays them into max_finder, returns the class.
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_score_streamer
    import fnn_pkg::*;
#(
    parameter int INDATA_WIDTH = DEF_INDATA_WIDTH,
    parameter int NN4          = DEF_NN4,
    parameter int TIMEOUT      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    score_valid,
    input  logic [CLASS_W-1:0]      score_idx,
    input  logic [INDATA_WIDTH-1:0] score_data,
    output logic                    score_ready,
    output logic [INDATA_WIDTH-1:0] mf_data,
    output logic                    mf_start,
    output logic                    mf_clear,
    input  logic                    mf_found,
    input  logic [CLASS_W-1:0]      mf_class,
    output logic [CLASS_W-1:0]      class_out,
    output logic                    class_valid,
    output logic                    err,
    output logic                    busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CLASS_W-1:0] c_last_k = CLASS_W'(NN4 - 1);
    localparam logic [TMO_W-1:0]   c_last_t = TMO_W'(TIMEOUT - 1);

    ss_state_t               r_state, w_next;
    logic [CLASS_W-1:0]      r_k, w_k_next;
    logic [TMO_W-1:0]        r_t, w_t_next;
    logic                    w_accept, w_wr, w_bad, w_all_valid;
    logic                    w_found, w_timeout, w_clear_mask;
    logic [INDATA_WIDTH-1:0] w_rd_data;

    logic [INDATA_WIDTH-1:0] r_mf_data;
    logic                    r_mf_start, r_mf_clear, r_class_valid, r_err, r_busy;
    logic [CLASS_W-1:0]      r_class_out;

    assign score_ready = (r_state == SS_IDLE) || (r_state == SS_FILL);
    assign w_accept    = score_valid && score_ready;
    assign w_wr        = w_accept && (score_idx < CLASS_W'(NN4));
    assign w_bad       = w_accept && !(score_idx < CLASS_W'(NN4));

    score_buffer #(
        .NN4          (NN4),
        .INDATA_WIDTH (INDATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_wr),
        .wr_idx    (score_idx),
        .wr_data   (score_data),
        .rd_idx    (w_k_next),
        .clear     (w_clear_mask),
        .rd_data   (w_rd_data),
        .all_valid (w_all_valid)
    );

    always_comb begin
        w_next       = r_state;
        w_k_next     = r_k;
        w_t_next     = r_t;
        w_found      = 1'b0;
        w_timeout    = 1'b0;
        w_clear_mask = 1'b0;
        case (r_state)
            SS_IDLE, SS_FILL: begin
                if (w_wr) begin
                    w_next = w_all_valid ? SS_CLEAR : SS_FILL;
                end
            end
            SS_CLEAR: begin
                w_next   = SS_STREAM;
                w_k_next = '0;
            end
            SS_STREAM: begin
                // found_max rises on the negedge of the final data cycle, so it is taken on this edge.
                if (r_k == c_last_k) begin
                    if (mf_found) begin
                        w_found      = 1'b1;
                        w_clear_mask = 1'b1;
                        w_next       = SS_IDLE;
                    end else begin
                        w_next   = SS_WAIT;
                        w_t_next = '0;
                    end
                end else begin
                    w_k_next = r_k + CLASS_W'(1);
                end
            end
            SS_WAIT: begin
                if (mf_found) begin
                    w_found      = 1'b1;
                    w_clear_mask = 1'b1;
                    w_next       = SS_IDLE;
                end else if (r_t == c_last_t) begin
                    w_timeout    = 1'b1;
                    w_clear_mask = 1'b1;
                    w_next       = SS_IDLE;
                end else begin
                    w_t_next = r_t + TMO_W'(1);
                end
            end
            default: begin
                w_next       = SS_IDLE;
                w_clear_mask = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SS_IDLE;
            r_k           <= '0;
            r_t           <= '0;
            r_mf_data     <= '0;
            r_mf_start    <= 1'b0;
            r_mf_clear    <= 1'b0;
            r_class_out   <= '0;
            r_class_valid <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_k           <= w_k_next;
            r_t           <= w_t_next;
            r_mf_clear    <= (w_next == SS_CLEAR);
            r_mf_start    <= (w_next == SS_STREAM);
            r_mf_data     <= (w_next == SS_STREAM) ? w_rd_data : '0;
            r_class_valid <= w_found;
            r_err         <= w_bad || w_timeout;
            r_busy        <= (w_next == SS_CLEAR) || (w_next == SS_STREAM) || (w_next == SS_WAIT);
            if (w_found) begin
                r_class_out <= mf_class;
            end
        end
    end

    assign mf_data     = r_mf_data;
    assign mf_start    = r_mf_start;
    assign mf_clear    = r_mf_clear;
    assign class_out   = r_class_out;
    assign class_valid = r_class_valid;
    assign err         = r_err;
    assign busy        = r_busy;

endmodule

`default_nettype wire
